// File: rtl/ie_ice_pkg.sv
// Shared definitions for the ICE ID/version reader blocks:
// FSM state encoding and the ID/version word width.
package ie_ice_pkg;

  localparam int unsigned IDVER_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } idver_state_t;

endpackage

// File: rtl/ie_sync2.sv
// Two-flop synchronizer for a multi-bit level bus. Individual bits may
// resolve on different cycles; the reader's stability check tolerates that.
module ie_sync2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back capture stages, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ie_idver_reader.sv
// ID/version reader: on a host request, samples the (asynchronous) FPGA
// ID/version pins until they have been stable for STABLE_CYC samples,
// latches the word, optionally shifts it out serially, then acknowledges.
// Optional feature macro: IE_IDVER_SERIAL_EN (serial SHIFT phase on SDO/SVALID).
module ie_idver_reader
  import ie_ice_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [15:0] EXPECT_ID   = 16'h9999
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [IDVER_W-1:0] IDVER_IN,
  input  logic               RDREQ,
  output logic               BUSY,
  output logic               RDACK,
  output logic [IDVER_W-1:0] IDVER_OUT,
  output logic               IDMATCH,
  output logic               IDERR,
  output logic               SDO,
  output logic               SVALID
);

  localparam logic [3:0] STABLE_L  = 4'(STABLE_CYC);
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYC);

  idver_state_t       state;
  idver_state_t       state_nxt;
  logic [IDVER_W-1:0] sync_word;
  logic [IDVER_W-1:0] prev_word;
  logic [3:0]         stab_cnt;
  logic [3:0]         stab_nxt;
  logic [7:0]         tmr;
  logic               accept;
  logic               timeout;

  ie_sync2 #(
    .WIDTH (IDVER_W)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (IDVER_IN),
    .q   (sync_word)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

`ifdef IE_IDVER_SERIAL_EN
  logic [4:0] bit_cnt;
`endif

  // Next-state logic, stability count and accept/timeout decisions
  always_comb begin
    state_nxt = state;
    stab_nxt  = 4'd1;
    accept    = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (RDREQ) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // First SAMPLE cycle always starts a fresh run of one sample
        if (tmr != '0 && sync_word == prev_word) stab_nxt = stab_cnt + 4'd1;
        if (stab_nxt == STABLE_L) begin
          accept = 1'b1;
`ifdef IE_IDVER_SERIAL_EN
          state_nxt = ST_SHIFT;
`else
          state_nxt = ST_DONE;
`endif
        end else if (tmr == TIMEOUT_L - 8'd1) begin
          timeout   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
`ifdef IE_IDVER_SERIAL_EN
        if (bit_cnt == 5'd31) state_nxt = ST_DONE;
`else
        state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sample history, SAMPLE counters and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_word <= '0;
      stab_cnt  <= '0;
      tmr       <= '0;
      IDVER_OUT <= '0;
      IDMATCH   <= 1'b0;
      IDERR     <= 1'b0;
    end else begin
      prev_word <= sync_word;
      if (state == ST_SAMPLE) begin
        stab_cnt <= stab_nxt;
        tmr      <= tmr + 8'd1;
      end else begin
        stab_cnt <= '0;
        tmr      <= '0;
      end
      if (accept) begin
        IDVER_OUT <= sync_word;
        IDMATCH   <= (sync_word[31:16] == EXPECT_ID);
        IDERR     <= 1'b0;
      end else if (timeout) begin
        IDERR <= 1'b1;
      end
    end
  end

`ifdef IE_IDVER_SERIAL_EN
  // Serial bit index; wraps 31 -> 0 naturally on the last SHIFT cycle
  always_ff @(posedge CLK) begin
    if (RST)                    bit_cnt <= '0;
    else if (state == ST_SHIFT) bit_cnt <= bit_cnt + 5'd1;
  end

  assign SVALID = (state == ST_SHIFT);
  assign SDO    = SVALID & IDVER_OUT[5'd31 - bit_cnt];
`else
  assign SVALID = 1'b0;
  assign SDO    = 1'b0;
`endif

  assign BUSY  = (state != ST_IDLE);
  assign RDACK = (state == ST_DONE);

endmodule

// File: tb/tb_ie_idver_reader.sv
// Self-checking bench for ie_idver_reader. Expected behaviour comes from
// a window-based reference: the read is accepted at the first SAMPLE cycle
// whose last STABLE samples (the pins delayed by two clocks) are identical.
module tb_ie_idver_reader;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TMO    = 64;
  localparam logic [15:0] EID    = 16'h9999;
`ifdef IE_IDVER_SERIAL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        RDREQ;
  logic [31:0] IDVER_IN;
  logic        BUSY, RDACK, IDMATCH, IDERR, SDO, SVALID;
  logic [31:0] IDVER_OUT;

  int errors = 0;
  int checks = 0;

  logic [31:0] stim [0:255];
  logic [31:0] exp_word;
  logic        exp_match, exp_err;

  int          obs_acks, obs_sv, obs_done;
  logic [31:0] obs_shift;

  ie_idver_reader #(
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TMO),
    .EXPECT_ID   (EID)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IDVER_IN  (IDVER_IN),
    .RDREQ     (RDREQ),
    .BUSY      (BUSY),
    .RDACK     (RDACK),
    .IDVER_OUT (IDVER_OUT),
    .IDMATCH   (IDMATCH),
    .IDERR     (IDERR),
    .SDO       (SDO),
    .SVALID    (SVALID)
  );

  always #5 CLK = ~CLK;

  // Request seen at edge r; SAMPLE cycle k sees the pin value driven before
  // edge r+k-2. Returns the accepting cycle k, or -1 on timeout.
  function automatic int model_accept(input int r);
    for (int k = STABLE; k <= int'(TMO); k++) begin
      bit ok = 1'b1;
      for (int m = 0; m < int'(STABLE); m++)
        if (stim[r+k-2-m] !== stim[r+k-2]) ok = 1'b0;
      if (ok) return k;
    end
    return -1;
  endfunction

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 256; i++) stim[i] = v;
  endtask

  // Drives one read from IDLE and compares every output on every cycle
  task automatic run_read(input int r, input int extra_req, input int rst_edge, input string tag);
    int k, a, done_e, len;
    bit rs;
    logic e_busy, e_ack, e_sv, e_sdo;
    logic [31:0] w;
    k      = model_accept(r);
    a      = (k > 0) ? r + k : -1;
    done_e = (k > 0) ? a + (SERIAL ? 32 : 0) : r + int'(TMO);
    len    = (rst_edge >= 0) ? rst_edge + 4 : done_e + 4;
    obs_acks = 0; obs_sv = 0; obs_done = -1; obs_shift = '0;
    for (int j = 0; j < len; j++) begin
      IDVER_IN = stim[j];
      RDREQ    = (j == r) || (j == extra_req);
      RST      = (j == rst_edge);
      @(posedge CLK);
      #1;
      rs = (rst_edge >= 0) && (j >= rst_edge);
      if (j == rst_edge) begin
        exp_word = '0; exp_match = 1'b0; exp_err = 1'b0;
      end else if (!rs && k > 0 && j == a) begin
        w = stim[a-2];
        exp_word = w; exp_match = (w[31:16] == EID); exp_err = 1'b0;
      end else if (!rs && k <= 0 && j == done_e) begin
        exp_err = 1'b1;
      end
      e_busy = !rs && j >= r && j <= done_e;
      e_ack  = !rs && j == done_e;
      e_sv   = !rs && SERIAL && k > 0 && j >= a && j < a + 32;
      e_sdo  = e_sv ? exp_word[31-(j-a)] : 1'b0;
      checks += 7;
      if (BUSY !== e_busy)       begin errors++; $display("FAIL %s busy @%0d: got %b want %b", tag, j, BUSY, e_busy); end
      if (RDACK !== e_ack)       begin errors++; $display("FAIL %s rdack @%0d: got %b want %b", tag, j, RDACK, e_ack); end
      if (SVALID !== e_sv)       begin errors++; $display("FAIL %s svalid @%0d: got %b want %b", tag, j, SVALID, e_sv); end
      if (SDO !== e_sdo)         begin errors++; $display("FAIL %s sdo @%0d: got %b want %b", tag, j, SDO, e_sdo); end
      if (IDVER_OUT !== exp_word) begin errors++; $display("FAIL %s idver_out @%0d: got %h want %h", tag, j, IDVER_OUT, exp_word); end
      if (IDMATCH !== exp_match) begin errors++; $display("FAIL %s idmatch @%0d: got %b want %b", tag, j, IDMATCH, exp_match); end
      if (IDERR !== exp_err)     begin errors++; $display("FAIL %s iderr @%0d: got %b want %b", tag, j, IDERR, exp_err); end
      if (RDACK === 1'b1) begin obs_acks++; if (obs_done < 0) obs_done = j; end
      if (SVALID === 1'b1) begin obs_sv++; obs_shift = {obs_shift[30:0], SDO}; end
    end
    RDREQ = 1'b0;
    RST   = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; RDREQ = 1'b1; IDVER_IN = $urandom;
    repeat (3) @(posedge CLK);
    #1;
    checks += 7;
    if (BUSY !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b want 0", BUSY); end
    if (RDACK !== 1'b0)     begin errors++; $display("FAIL reset rdack: got %b want 0", RDACK); end
    if (IDVER_OUT !== '0)   begin errors++; $display("FAIL reset idver_out: got %h want 0", IDVER_OUT); end
    if (IDMATCH !== 1'b0)   begin errors++; $display("FAIL reset idmatch: got %b want 0", IDMATCH); end
    if (IDERR !== 1'b0)     begin errors++; $display("FAIL reset iderr: got %b want 0", IDERR); end
    if (SDO !== 1'b0)       begin errors++; $display("FAIL reset sdo: got %b want 0", SDO); end
    if (SVALID !== 1'b0)    begin errors++; $display("FAIL reset svalid: got %b want 0", SVALID); end
    RST = 1'b0; RDREQ = 1'b0;
    exp_word = '0; exp_match = 1'b0; exp_err = 1'b0;
  endtask

  task automatic test_default_read;
    fill_const(32'h9999_0102);
    run_read(3, -1, -1, "default");
    checks += 6;
    if (IDVER_OUT !== 32'h9999_0102) begin errors++; $display("FAIL default word: got %h want 99990102", IDVER_OUT); end
    if (IDMATCH !== 1'b1) begin errors++; $display("FAIL default idmatch: got %b want 1", IDMATCH); end
    if (obs_acks != 1)    begin errors++; $display("FAIL default ack_count: got %0d want 1", obs_acks); end
    if (obs_sv != (SERIAL ? 32 : 0)) begin errors++; $display("FAIL default sv_count: got %0d want %0d", obs_sv, SERIAL ? 32 : 0); end
    if (obs_shift !== (SERIAL ? 32'h9999_0102 : 32'h0)) begin errors++; $display("FAIL default serial_word: got %h", obs_shift); end
    if (obs_done != 3 + 4 + (SERIAL ? 32 : 0)) begin errors++; $display("FAIL default done_edge: got %0d want %0d", obs_done, 7 + (SERIAL ? 32 : 0)); end
  endtask

  task automatic test_id_mismatch;
    fill_const(32'h1234_0001);
    run_read(3, -1, -1, "mismatch");
    checks += 4;
    if (IDVER_OUT !== 32'h1234_0001) begin errors++; $display("FAIL mismatch word: got %h want 12340001", IDVER_OUT); end
    if (IDMATCH !== 1'b0) begin errors++; $display("FAIL mismatch idmatch: got %b want 0", IDMATCH); end
    if (IDERR !== 1'b0)   begin errors++; $display("FAIL mismatch iderr: got %b want 0", IDERR); end
    if (obs_acks != 1)    begin errors++; $display("FAIL mismatch ack_count: got %0d want 1", obs_acks); end
  endtask

  task automatic test_toggle_timeout;
    for (int i = 0; i < 256; i++) stim[i] = ((i / 2) % 2 != 0) ? 32'h9999_00AA : 32'h9999_0055;
    run_read(3, -1, -1, "toggle");
    checks += 5;
    if (IDERR !== 1'b1) begin errors++; $display("FAIL toggle iderr: got %b want 1", IDERR); end
    if (IDVER_OUT !== 32'h1234_0001) begin errors++; $display("FAIL toggle word: got %h want 12340001", IDVER_OUT); end
    if (obs_sv != 0)    begin errors++; $display("FAIL toggle sv_count: got %0d want 0", obs_sv); end
    if (obs_acks != 1)  begin errors++; $display("FAIL toggle ack_count: got %0d want 1", obs_acks); end
    if (obs_done != 3 + 64) begin errors++; $display("FAIL toggle done_edge: got %0d want 67", obs_done); end
  endtask

  task automatic test_glitch;
    fill_const(32'h9999_0003);
    stim[5] = 32'hDEAD_BEEF;
    run_read(3, -1, -1, "glitch");
    checks += 4;
    if (IDVER_OUT !== 32'h9999_0003) begin errors++; $display("FAIL glitch word: got %h want 99990003", IDVER_OUT); end
    if (IDERR !== 1'b0) begin errors++; $display("FAIL glitch iderr: got %b want 0", IDERR); end
    if (obs_acks != 1)  begin errors++; $display("FAIL glitch ack_count: got %0d want 1", obs_acks); end
    if (obs_done != 3 + 8 + (SERIAL ? 32 : 0)) begin errors++; $display("FAIL glitch done_edge: got %0d want %0d", obs_done, 11 + (SERIAL ? 32 : 0)); end
  endtask

  task automatic test_second_req;
    fill_const(32'h9999_0A0B);
    run_read(3, SERIAL ? 3 + 4 + 5 : 3 + 2, -1, "second_req");
    checks += 2;
    if (obs_acks != 1) begin errors++; $display("FAIL second_req ack_count: got %0d want 1", obs_acks); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL second_req idle_after: got busy=%b want 0", BUSY); end
  endtask

  task automatic test_reset_mid;
    fill_const(32'h9999_0102);
    run_read(3, -1, SERIAL ? 3 + 4 + 11 : 3 + 2, "reset_mid");
    checks += 2;
    if (obs_acks != 0)    begin errors++; $display("FAIL reset_mid ack_count: got %0d want 0", obs_acks); end
    if (IDVER_OUT !== '0) begin errors++; $display("FAIL reset_mid word: got %h want 0", IDVER_OUT); end
    fill_const(32'h9999_0102);
    run_read(3, -1, -1, "after_reset");
    checks += 2;
    if (obs_acks != 1) begin errors++; $display("FAIL after_reset ack_count: got %0d want 1", obs_acks); end
    if (IDVER_OUT !== 32'h9999_0102) begin errors++; $display("FAIL after_reset word: got %h want 99990102", IDVER_OUT); end
  endtask

  task automatic test_random;
    logic [31:0] pool [0:2];
    int idx, run, sel;
    for (int n = 0; n < 8; n++) begin
      pool[0] = {EID, 16'($urandom)};
      pool[1] = $urandom;
      pool[2] = {EID, 16'($urandom)};
      idx = 0;
      while (idx < 256) begin
        sel = $urandom_range(0, 2);
        run = $urandom_range(1, 7);
        for (int i = 0; i < run && idx < 256; i++) begin
          stim[idx] = pool[sel];
          idx++;
        end
      end
      run_read(3, -1, -1, "random");
      checks++;
      if (obs_acks != 1) begin errors++; $display("FAIL random ack_count: got %0d want 1", obs_acks); end
    end
  endtask

  initial begin
    RST = 1'b0; RDREQ = 1'b0; IDVER_IN = '0;
    test_reset;
    test_default_read;
    test_id_mismatch;
    test_toggle_timeout;
    test_glitch;
    test_second_req;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
